// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 timing constants, framebuffer geometry and the
//               row/column to framebuffer address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE  = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int SCALE_LOG2 = 2;
    localparam int CNT_W      = 10;

    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int FB_DEPTH   = FB_W * FB_H;
    localparam int FB_AW      = 15;
    localparam int COLOUR_W   = 3;

    // row*160 + col, with the constant multiply folded into row*128 + row*32
    function automatic logic [FB_AW-1:0] fb_addr(input logic [6:0] row,
                                                 input logic [7:0] col);
        logic [FB_AW-1:0] w_row_ext;
        w_row_ext = {8'd0, row};
        return (w_row_ext << 7) + (w_row_ext << 5) + {7'd0, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : fb_ram
// Description : Simple dual-port framebuffer RAM, one write port and one
//               synchronous read port returning old data on collision.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int WIDTH = COLOUR_W,
    parameter int AW    = FB_AW
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset on the array or read register so the tools map this onto
    // block RAM; both accesses in one process give read-before-write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout
// Description : 160x120x3 framebuffer with a pixel-write port, scanned out as
//               640x480@60 VGA with 4x replication through a 2-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       writeEn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       frame_start
);

    localparam int CW      = vga_pkg::CNT_W;
    localparam int AW      = vga_pkg::FB_AW;
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_h_last   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] c_v_last   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] c_h_vis    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] c_v_vis    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] c_hs_first = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] c_hs_last  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_vs_first = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] c_vs_last  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [7:0]    c_fb_w     = 8'(vga_pkg::FB_W);
    localparam logic [6:0]    c_fb_h     = 7'(vga_pkg::FB_H);

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    logic          w_visible;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_frame;
    logic [6:0]    w_row;
    logic [7:0]    w_col;
    logic [AW-1:0] w_rd_addr;

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [2:0]    w_rd_data;

    logic          r_s1_valid;
    logic          r_s1_visible;
    logic          r_s1_hs_n;
    logic          r_s1_vs_n;
    logic          r_s1_frame;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: decode from the counters
    // ------------------------------------------------------------------
    always_comb begin
        w_visible = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
        w_hs_n    = !((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last));
        w_vs_n    = !((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last));
        w_frame   = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_row     = 7'(r_v_cnt >> SCALE_LOG2);
        w_col     = 8'(r_h_cnt >> SCALE_LOG2);
        w_rd_addr = w_visible ? vga_pkg::fb_addr(w_row, w_col) : '0;
    end

    // Out-of-range writes are dropped rather than wrapped onto another row
    always_comb begin
        w_wr_en   = writeEn && (x < c_fb_w) && (y < c_fb_h);
        w_wr_addr = vga_pkg::fb_addr(y, x);
    end

    fb_ram #(
        .DEPTH (vga_pkg::FB_DEPTH),
        .WIDTH (vga_pkg::COLOUR_W),
        .AW    (AW)
    ) u_fb_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (colour),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Stage 1: control travels alongside the RAM read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_visible <= 1'b0;
            r_s1_hs_n    <= 1'b1;
            r_s1_vs_n    <= 1'b1;
            r_s1_frame   <= 1'b0;
        end else begin
            r_s1_valid   <= 1'b1;
            r_s1_visible <= w_visible;
            r_s1_hs_n    <= w_hs_n;
            r_s1_vs_n    <= w_vs_n;
            r_s1_frame   <= w_frame;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered pins; a flushed stage 1 presents idle values
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset || !r_s1_valid) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= {8{r_s1_visible & w_rd_data[2]}};
            vga_g       <= {8{r_s1_visible & w_rd_data[1]}};
            vga_b       <= {8{r_s1_visible & w_rd_data[0]}};
            vga_hs      <= r_s1_hs_n;
            vga_vs      <= r_s1_vs_n;
            vga_blank_n <= r_s1_visible;
            frame_start <= r_s1_frame;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scanout
// Description : Self-checking bench for vga_scanout using a shortened frame
//               (28 visible lines) and full 800-cycle line timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 28,  VF = 1,  VS = 2,  VB = 1;
    localparam int H_TOT = HV + HF + HS + HB;
    localparam int V_TOT = VV + VF + VS + VB;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
    } out_t;

    typedef struct {
        out_t o;
        logic pix;
        int   h;
        int   v;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       writeEn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, frame_start;

    vga_scanout #(
        .V_VISIBLE (VV),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .writeEn     (writeEn),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    logic [2:0] fbm [19200];
    ent_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         mh = 0, mv = 0;
    int         cyc = 0, rel_cyc = -1, last_fs = -1;
    int         hl = 0, bh = 0, frames_seen = 0;
    logic       px_written = 1'b0, oor_done = 1'b0, coll_done = 1'b0;

    localparam out_t R_OUT = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, bn: 1'b0, fs: 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic out_t model_pix(input int h, input int v);
        out_t       o;
        logic       vis;
        logic [2:0] c;
        vis  = (h < HV) && (v < VV);
        c    = vis ? fbm[(v / 4) * 160 + (h / 4)] : 3'b000;
        o.r  = c[2] ? 8'hFF : 8'h00;
        o.g  = c[1] ? 8'hFF : 8'h00;
        o.b  = c[0] ? 8'hFF : 8'h00;
        o.hs = !((h >= HV + HF) && (h < HV + HF + HS));
        o.vs = !((v >= VV + VF) && (v < VV + VF + VS));
        o.bn = vis;
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    // One clock: drive inputs, queue the expectation, then compare what comes out
    task automatic step(input logic rst_n, input logic we, input int xx, input int yy,
                        input logic [2:0] col);
        ent_t        e;
        out_t        obs;
        logic [23:0] rgb_exp;
        reset   = rst_n;
        writeEn = we;
        x       = xx[7:0];
        y       = yy[6:0];
        colour  = col;
        if (!rst_n) begin
            q.delete();
            e.o = R_OUT; e.pix = 1'b0; e.h = 0; e.v = 0;
            q.push_back(e);
            q.push_back(e);
            mh = 0; mv = 0;
            last_fs = -1;
        end else begin
            e.o = model_pix(mh, mv); e.pix = 1'b1; e.h = mh; e.v = mv;
            q.push_back(e);
            if (mh == H_TOT - 1) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        if (we && xx < 160 && yy < 120) fbm[yy * 160 + xx] = col;

        @(posedge clk);
        #1;
        cyc++;
        e   = q.pop_front();
        obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start};
        check("scan", 32'(obs), 32'(e.o));

        if (frame_start === 1'b1) begin
            if (rel_cyc >= 0) begin
                check("release_to_frame_start", 32'(cyc - rel_cyc), 32'd2);
                rel_cyc = -1;
            end
            if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
        end

        if (e.pix) begin
            if (e.h == 0) begin hl = 0; bh = 0; end
            hl += (vga_hs === 1'b0) ? 1 : 0;
            bh += (vga_blank_n === 1'b1) ? 1 : 0;
            if (e.h == H_TOT - 1) begin
                check("hs_low_width", 32'(hl), 32'd96);
                check("blank_high_width", 32'(bh), (e.v < VV) ? 32'd640 : 32'd0);
            end
            if (e.h == 655 || e.h == 752) check("hs_edge_high", 32'(vga_hs), 32'd1);
            if (e.h == 656 || e.h == 751) check("hs_edge_low", 32'(vga_hs), 32'd0);

            if (px_written && e.h >= 11 && e.h <= 16 && e.v >= 7 && e.v <= 12) begin
                rgb_exp = (e.h >= 12 && e.h <= 15 && e.v >= 8 && e.v <= 11) ? 24'hFF00FF : 24'h000000;
                check("pixel_3_2", 32'({vga_r, vga_g, vga_b}), 32'(rgb_exp));
            end
            if (oor_done && e.h == 0 && (e.v == 20 || e.v == 24))
                check("out_of_range_kept", 32'({vga_r, vga_g, vga_b}), 32'h00FF00);
            if (e.h == 0 && e.v == 0) frames_seen++;
            if (coll_done && e.h == 0 && e.v == 0)
                check("collision_pixel", 32'({vga_r, vga_g, vga_b}),
                      (frames_seen == 1) ? 32'h000000 : 32'hFFFFFF);
            if (coll_done && e.h == 2 && e.v == 0)
                check("collision_write_landed", 32'({vga_r, vga_g, vga_b}), 32'hFFFFFF);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 3'b000);
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) fbm[i] = 3'b000;
        reset = 1'b0; writeEn = 1'b0; x = '0; y = '0; colour = '0;

        // Held in reset while the visible rows are cleared and two probes seeded
        for (int i = 0; i < 7 * 160; i++) step(1'b0, 1'b1, i % 160, i / 160, 3'b000);
        step(1'b0, 1'b1, 0, 5, 3'b010);
        step(1'b0, 1'b1, 0, 6, 3'b010);

        // Release; the first running cycle also writes address 0 under its own read
        rel_cyc = cyc;
        coll_done = 1'b1;
        step(1'b1, 1'b1, 0, 0, 3'b111);
        step(1'b1, 1'b1, 160, 5, 3'b100);
        step(1'b1, 1'b1, 0, 120, 3'b100);
        oor_done = 1'b1;
        step(1'b1, 1'b1, 3, 2, 3'b101);
        px_written = 1'b1;

        // Rest of frame 1, then into frame 2 up to line 10, column 300
        idle(FRAME + 10 * H_TOT + 300 - 4);

        // Mid-frame reset
        step(1'b0, 1'b0, 0, 0, 3'b000);
        check("midframe_reset_vs", 32'(vga_vs), 32'd1);
        check("midframe_reset_blank", 32'(vga_blank_n), 32'd0);
        step(1'b0, 1'b0, 0, 0, 3'b000);
        step(1'b0, 1'b0, 0, 0, 3'b000);

        rel_cyc = cyc;
        idle(2 * H_TOT + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
